// File: rtl/axis_arb_pkg.sv
// ============================================================================
// Module   : axis_arb_pkg
// Brief    : Shared FSM state type and width helper for the packet arbiter mux.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package axis_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero, so ports stay legal for any NUM_CH.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
// Module   : axis_rr_arbiter
// Brief    : Combinational rotate-priority encoder; the first request at or
//            after ptr (ascending, modulo NUM_CH) wins.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              gnt_valid,
    output logic [CH_W-1:0]   gnt_id
);

    logic [NUM_CH-1:0] w_rot;
    logic [CH_W:0]     w_sum;

    always_comb begin
        // Bit k of w_rot is the request of channel (ptr + k) mod NUM_CH.
        w_rot     = NUM_CH'({req, req} >> ptr);
        gnt_valid = |w_rot;
        w_sum     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, ptr} + (CH_W+1)'(k);
            end
        end
        if (w_sum >= (CH_W+1)'(NUM_CH)) begin
            w_sum = w_sum - (CH_W+1)'(NUM_CH);
        end
        gnt_id = w_sum[CH_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/axis_pkt_arb_mux.sv
// ============================================================================
// Module   : axis_pkt_arb_mux
// Brief    : N-to-1 stream mux with packet-level locking and registered output.
//            Define AXIS_ARB_RR_EN for round-robin; otherwise sel chooses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_pkt_arb_mux
    import axis_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CH_W-1:0]          sel,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_valid,
    input  logic [NUM_CH-1:0]        s_last,
    output logic [NUM_CH-1:0]        s_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic [CH_W-1:0]          grant_id,
    output logic                     busy
);

    // Zero-padded request vectors let any CH_W-bit index be used safely.
    localparam int PAD_W = 1 << CH_W;

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [CH_W-1:0]   r_grant_id;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_m_last;

    logic [PAD_W-1:0]  w_valid_pad;
    logic [PAD_W-1:0]  w_last_pad;
    logic              w_win_valid;
    logic [CH_W-1:0]   w_win_id;
    logic              w_out_free;
    logic              w_slave_xfer;
    logic              w_beat_last;
    logic [DATA_W-1:0] w_beat_data;

    assign w_valid_pad = PAD_W'(s_valid);
    assign w_last_pad  = PAD_W'(s_last);

`ifdef AXIS_ARB_RR_EN
    logic [CH_W-1:0] r_rr_ptr;
    logic            w_unused_sel;

    assign w_unused_sel = ^sel;

    axis_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req       (s_valid),
        .ptr       (r_rr_ptr),
        .gnt_valid (w_win_valid),
        .gnt_id    (w_win_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_IDLE && w_win_valid) begin
            r_rr_ptr <= (w_win_id == CH_W'(NUM_CH - 1)) ? '0 : w_win_id + CH_W'(1);
        end
    end
`else
    // Out-of-range sel lands on a padding zero and therefore never grants.
    assign w_win_valid = w_valid_pad[sel];
    assign w_win_id    = sel;
`endif

    assign w_out_free   = !r_m_valid || m_ready;
    assign w_slave_xfer = (r_state == ST_LOCKED) && w_out_free && w_valid_pad[r_grant_id];
    assign w_beat_last  = w_last_pad[r_grant_id];

    always_comb begin
        w_beat_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant_id == CH_W'(i)) begin
                w_beat_data = s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_win_valid) w_next_state = ST_LOCKED;
            ST_LOCKED: if (w_slave_xfer && w_beat_last) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = '0;
        if (r_state == ST_LOCKED && w_out_free) begin
            s_ready = NUM_CH'(1) << r_grant_id;
        end
        busy = (r_state == ST_LOCKED);
    end

    // grant_id reads 0 whenever the FSM is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_id <= '0;
        end else if (r_state == ST_IDLE && w_win_valid) begin
            r_grant_id <= w_win_id;
        end else if (r_state == ST_LOCKED && w_next_state == ST_IDLE) begin
            r_grant_id <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_slave_xfer) begin
            r_m_data  <= w_beat_data;
            r_m_last  <= w_beat_last;
            r_m_valid <= 1'b1;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;
    assign m_last   = r_m_last;
    assign grant_id = r_grant_id;

endmodule

`default_nettype wire
